// File: rtl/vga_timing_rx_if.sv
// Sync inputs and recovered timing outputs of the VGA timing receiver.
// The video source drives the syncs; the receiver drives everything else.
interface vga_timing_rx_if;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_active;
    logic       locked;
    logic [9:0] h_total;
    logic [9:0] v_total;
    logic       frame_start;
    logic       sync_error;

    modport master (
        output hsync_in,
        output vsync_in,
        input  pixel_x,
        input  pixel_y,
        input  video_active,
        input  locked,
        input  h_total,
        input  v_total,
        input  frame_start,
        input  sync_error
    );

    modport slave (
        input  hsync_in,
        input  vsync_in,
        output pixel_x,
        output pixel_y,
        output video_active,
        output locked,
        output h_total,
        output v_total,
        output frame_start,
        output sync_error
    );
endinterface

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame periods from the sync pulses,
// recovers the pixel position and declares lock after stable frames.
module vga_timing_rx #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_SYNC_START = 656,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic           clk,
    input  logic           reset,
    vga_timing_rx_if.slave bus
);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [9:0] CMAX   = 10'd1023;
    localparam logic [9:0] HACT   = 10'(H_ACTIVE);
    localparam logic [9:0] VACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HSS    = 10'(H_SYNC_START);
    localparam logic [9:0] VSS    = 10'(V_SYNC_START);
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    logic       h_reg;
    logic       v_reg;
    logic       h_edge;
    logic       v_edge;
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] h_cnt;
    logic [9:0] l_cnt;
    logic [9:0] h_tot;
    logic [9:0] v_tot;
    logic       frame_ok;
    logic [1:0] state;
    logic [7:0] match_cnt;
    logic       fs;
    logic       serr;
    logic       is_locked;
    logic       h_bad;
    logic       v_bad;
    logic       h_sat;
    logic       l_sat;
    logic       lock_lost;
    logic       frame_good;

    assign h_edge     = h_reg & ~bus.hsync_in;
    assign v_edge     = v_reg & ~bus.vsync_in;
    assign is_locked  = (state == LOCKED);
    assign h_bad      = h_edge && (h_cnt != h_tot);
    assign v_bad      = v_edge && (l_cnt != v_tot);
    // Counters about to hit their ceiling mean a sync pulse went missing.
    assign h_sat      = !h_edge && (h_cnt == CMAX - 10'd1);
    assign l_sat      = h_edge && !v_edge && (l_cnt == CMAX - 10'd1);
    assign lock_lost  = is_locked && (h_bad || v_bad || h_sat || l_sat);
    // The line ending on this V edge must also have the right period.
    assign frame_good = frame_ok && !h_bad;

    assign bus.pixel_x      = px;
    assign bus.pixel_y      = py;
    assign bus.h_total      = h_tot;
    assign bus.v_total      = v_tot;
    assign bus.locked       = is_locked;
    assign bus.frame_start  = fs;
    assign bus.sync_error   = serr;
    assign bus.video_active = is_locked && (px < HACT) && (py < VACT);

    // Previous sync levels for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_reg <= 1'b1;
            v_reg <= 1'b1;
        end else begin
            h_reg <= bus.hsync_in;
            v_reg <= bus.vsync_in;
        end
    end

    // Horizontal position: snaps to the sync position, wraps at the line end once locked.
    always_ff @(posedge clk) begin
        if (reset) begin
            px <= '0;
        end else if (h_edge) begin
            px <= HSS;
        end else if (is_locked && px == h_tot - 10'd1) begin
            px <= '0;
        end else if (px != CMAX) begin
            px <= px + 10'd1;
        end
    end

    // Vertical position: V edge wins over a coincident H edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            py <= '0;
        end else if (v_edge) begin
            py <= VSS;
        end else if (h_edge) begin
            if (is_locked && py == v_tot - 10'd1) begin
                py <= '0;
            end else if (py != CMAX) begin
                py <= py + 10'd1;
            end
        end
    end

    // Line period measurement.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            h_tot <= '0;
        end else if (h_edge) begin
            h_cnt <= 10'd1;
            h_tot <= h_cnt;
        end else if (h_cnt != CMAX) begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Frame length in lines; a coincident H edge is the first line of the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            l_cnt <= '0;
            v_tot <= '0;
        end else if (v_edge) begin
            v_tot <= l_cnt;
            l_cnt <= {9'd0, h_edge};
        end else if (h_edge && l_cnt != CMAX) begin
            l_cnt <= l_cnt + 10'd1;
        end
    end

    // Tracks whether every line of the current frame had the expected period.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_ok <= 1'b0;
        end else if (v_edge) begin
            frame_ok <= 1'b1;
        end else if (h_bad) begin
            frame_ok <= 1'b0;
        end
    end

    // Lock state machine plus the frame_start and sync_error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            match_cnt <= '0;
            fs        <= 1'b0;
            serr      <= 1'b0;
        end else begin
            fs   <= v_edge;
            serr <= 1'b0;
            case (state)
                SEARCH: begin
                    if (v_edge) begin
                        state     <= TRACK;
                        match_cnt <= '0;
                    end
                end
                TRACK: begin
                    if (v_edge) begin
                        if (!v_bad && frame_good) begin
                            match_cnt <= match_cnt + 8'd1;
                            if (match_cnt + 8'd1 >= LOCK_N) begin
                                state <= LOCKED;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (lock_lost) begin
                        state     <= SEARCH;
                        match_cnt <= '0;
                        serr      <= 1'b1;
                    end
                end
                default: begin
                    state     <= SEARCH;
                    match_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed and randomized checks of vga_timing_rx using a scaled-down
// 40x20 raster generated from plain coordinate arithmetic.
module tb_vga_timing_rx;
    localparam int HT    = 40;
    localparam int HA    = 32;
    localparam int HS    = 33;
    localparam int HW    = 4;
    localparam int VT    = 20;
    localparam int VA    = 15;
    localparam int VS    = 16;
    localparam int VW    = 2;
    localparam int FRAME = HT * VT;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vga_timing_rx_if bus ();

    vga_timing_rx #(
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .H_SYNC_START(HS),
        .V_SYNC_START(VS),
        .LOCK_FRAMES (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int sx = 0, sy = 0, smp_x = 0, smp_y = 0;
    bit short_line = 0, hfall = 0, vfall = 0, prev_hs = 1, prev_vs = 1;
    int nv, early, nse, hit, mism, va, both0, nfs, fs_last, fs_gap, ey;
    int k, h, r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit hs, input bit vs);
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        hfall   = prev_hs && !hs;
        vfall   = prev_vs && !vs;
        prev_hs = hs;
        prev_vs = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic src_step();
        bit hs, vs;
        hs = !(sx >= HS && sx < HS + HW);
        vs = !((sy == VS && sx >= HS) || (sy > VS && sy < VS + VW) ||
               (sy == VS + VW && sx < HS));
        smp_x = sx;
        smp_y = sy;
        drive(hs, vs);
        if (sx == HT - 1 || (short_line && sx == HT - 2)) begin
            sx = 0;
            sy = (sy + 1) % VT;
            short_line = 0;
        end else begin
            sx++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_px"}, 32'(bus.pixel_x), 0);
        check({tag, "_py"}, 32'(bus.pixel_y), 0);
        check({tag, "_ht"}, 32'(bus.h_total), 0);
        check({tag, "_vt"}, 32'(bus.v_total), 0);
        check({tag, "_lock"}, 32'(bus.locked), 0);
        check({tag, "_va"}, 32'(bus.video_active), 0);
        check({tag, "_fs"}, 32'(bus.frame_start), 0);
        check({tag, "_se"}, 32'(bus.sync_error), 0);
    endtask

    initial begin
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        reset = 1'b1;
        repeat (2 + $urandom_range(0, 3)) drive(1'b1, 1'b1);
        check_zero("rst");
        reset = 1'b0;

        // Acquire lock from reset: locked after the 4th vsync fall.
        nv = 0;
        early = 0;
        for (int i = 0; i < 6 * FRAME && nv < 4; i++) begin
            src_step();
            if (vfall) nv++;
            if (nv < 4 && bus.locked === 1'b1) early++;
        end
        check("lock_vedges", nv, 4);
        check("lock_rise", 32'(bus.locked), 1);
        check("lock_early", early, 0);
        check("h_total", 32'(bus.h_total), HT);
        check("v_total", 32'(bus.v_total), VT);

        // Two clean locked frames against the coordinate model.
        for (int i = 0; i < FRAME; i++) begin
            if (sx == 0 && sy == 0) break;
            src_step();
        end
        mism = 0; va = 0; both0 = 0; nfs = 0; fs_last = 0; fs_gap = 0; nse = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            src_step();
            ey = (smp_x >= HS) ? smp_y : (smp_y + VT - 1) % VT;
            if (bus.pixel_x !== 10'(smp_x) || bus.pixel_y !== 10'(ey) ||
                bus.video_active !== 1'(smp_x < HA && ey < VA)) mism++;
            if (bus.video_active === 1'b1) va++;
            if (bus.pixel_x === 10'd0 && bus.pixel_y === 10'd0) both0++;
            if (bus.frame_start === 1'b1) begin
                if (nfs > 0) fs_gap = i - fs_last;
                fs_last = i;
                nfs++;
            end
            if (bus.sync_error === 1'b1) nse++;
        end
        check("pos_mism", mism, 0);
        check("active_cnt", va, 2 * HA * VA);
        check("origin_cnt", both0, 2);
        check("fs_cnt", nfs, 2);
        check("fs_gap", fs_gap, FRAME);
        check("clean_serr", nse, 0);

        // One line shortened by a clock.
        k = $urandom_range(2, 12);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (sx == HS + 1 && sy == k) break;
            src_step();
        end
        short_line = 1;
        nse = 0; early = 0; hit = 0;
        for (int i = 0; i < 2 * HT && hit == 0; i++) begin
            src_step();
            if (bus.sync_error === 1'b1) nse++;
            if (smp_x == HS && smp_y == k + 1) hit = 1;
            else if (bus.locked !== 1'b1) early++;
        end
        check("short_hit", hit, 1);
        check("short_err", 32'(bus.sync_error), 1);
        check("short_drop", 32'(bus.locked), 0);
        check("short_hold", early, 0);
        nv = 0;
        early = 0;
        for (int i = 0; i < 6 * FRAME && nv < 3; i++) begin
            src_step();
            if (vfall) nv++;
            if (bus.sync_error === 1'b1) nse++;
            if (nv < 3 && bus.locked === 1'b1) early++;
        end
        check("relock_vedges", nv, 3);
        check("relock", 32'(bus.locked), 1);
        check("relock_early", early, 0);
        check("short_serr_cnt", nse, 1);

        // hsync stuck high while locked.
        h = $urandom_range(2, 10);
        for (int i = 0; i < 2 * FRAME; i++) begin
            src_step();
            if (smp_x == HS && smp_y == h) break;
        end
        check("wd_pre_lock", 32'(bus.locked), 1);
        nse = 0;
        early = 0;
        for (int i = 1; i <= 2100; i++) begin
            drive(1'b1, 1'b1);
            if (bus.sync_error === 1'b1) nse++;
            if (i < 1022 && bus.locked !== 1'b1) early++;
            if (i == 1022) begin
                check("wd_err", 32'(bus.sync_error), 1);
                check("wd_lock", 32'(bus.locked), 0);
            end
        end
        check("wd_early", early, 0);
        check("wd_serr_cnt", nse, 1);
        check("wd_px_sat", 32'(bus.pixel_x), 1023);
        check("wd_htot", 32'(bus.h_total), HT);
        sx = 0;
        sy = (h + 1) % VT;
        for (int i = 0; i < 10 * FRAME; i++) begin
            src_step();
            if (bus.locked === 1'b1) break;
        end
        check("wd_relock", 32'(bus.locked), 1);

        // Reset pulse mid-frame while locked.
        r = $urandom_range(0, 30);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (sx == r && sy == 8) break;
            src_step();
        end
        reset = 1'b1;
        src_step();
        reset = 1'b0;
        check_zero("mid_rst");
        nv = 0; early = 0; nse = 0;
        for (int i = 0; i < 6 * FRAME && nv < 4; i++) begin
            src_step();
            if (vfall) nv++;
            if (bus.sync_error === 1'b1) nse++;
            if (nv < 4 && bus.locked === 1'b1) early++;
        end
        check("rst_vedges", nv, 4);
        check("rst_relock", 32'(bus.locked), 1);
        check("rst_early", early, 0);
        check("rst_serr", nse, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-003 Parameter H_SYNC_START, 656, pixel_x value assigned to the first cycle of the hsync pulse.
REQ-004 Parameter V_SYNC_START, 490, pixel_y value assigned to the line in which vsync first goes low.
REQ-005 Parameter LOCK_FRAMES, 2, consecutive matching frames required to lock.
REQ-006 clk  input  1  pixel clock; the only clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 hsync_in  input  1  horizontal sync, active-low pulse, synchronous to clk.
REQ-009 vsync_in  input  1  vertical sync, active-low pulse, synchronous to clk.
REQ-010 pixel_x  output  10  recovered horizontal position.
REQ-011 pixel_y  output  10  recovered vertical position.
REQ-012 video_active  output  1  high when recovered position is visible and the block is locked.
REQ-013 locked  output  1  high while timing is stable.
REQ-014 h_total  output  10  last measured line period in clocks.
REQ-015 v_total  output  10  last measured frame period in lines.
REQ-016 frame_start  output  1  one-cycle pulse after each vsync falling edge.
REQ-017 sync_error  output  1  one-cycle pulse when lock is lost.

Function
REQ-018 Both sync inputs are registered once; a falling edge is detected when the registered value is 1 and the current input is 0. All outputs lag the inputs by exactly one clock.
REQ-019 H edge: pixel_x <= H_SYNC_START; otherwise pixel_x increments by 1, saturating at 1023.
REQ-020 H period counter: cleared to 1 on an H edge, otherwise increments, saturating at 1023. On an H edge, h_total <= counter value before clearing.
REQ-021 Line counter: increments on each H edge, saturating at 1023. On a V edge, v_total <= line count, then the line count is cleared to 0.
REQ-022 pixel_y: on a V edge, <= V_SYNC_START. On an H edge without a V edge, increments and wraps to 0 when equal to v_total-1 while locked; otherwise saturates at 1023. Simultaneous H and V edges: V edge sets pixel_y, H edge still updates pixel_x.
REQ-023 frame_ok flag: set on a V edge; cleared by any H edge whose measured period differs from the current h_total.
REQ-024 FSM SEARCH: locked=0. The first V edge moves to TRACK and clears match_cnt.
REQ-025 FSM TRACK: on each V edge, if line count == v_total and frame_ok, match_cnt increments; otherwise match_cnt is cleared. When match_cnt reaches LOCK_FRAMES, the FSM moves to LOCKED.
REQ-026 FSM LOCKED: locked=1. The FSM returns to SEARCH and pulses sync_error for one cycle on any of: an H edge with period != h_total; a V edge with line count != v_total; the H period counter reaching 1023; the line counter reaching 1023.
REQ-027 video_active = locked && pixel_x < H_ACTIVE && pixel_y < V_ACTIVE.
REQ-028 frame_start pulses for one cycle in the cycle after every V edge, in any state.

Reset
REQ-029 While reset is high, at the next clk edge: pixel_x=0, pixel_y=0, h_total=0, v_total=0, locked=0, video_active=0, frame_start=0, sync_error=0, FSM=SEARCH, match_cnt=0, all counters=0, and both sync registers=1.
REQ-030 Reset asserted mid-frame or while LOCKED takes effect in one cycle, with no sync_error pulse; edge detection resumes on the first clock after reset deasserts.

Verification
REQ-031 800x525 timing (hsync low for 96 clocks from x=656; vsync low for 2 lines from y=490) -> h_total=800, v_total=525; locked rises on the cycle after the 4th vsync falling edge.
REQ-032 Locked stream -> video_active high for exactly 640x480 cycles per frame; pixel_x=0 and pixel_y=0 coincide in the same cycle once per frame.
REQ-033 While locked, shorten one line to 799 clocks -> sync_error pulses once; locked drops on the cycle after that H edge; relock occurs after 3 further clean frames.
REQ-034 hsync held high for 1100 clocks while locked -> at the 1023rd clock: sync_error pulses, locked=0, pixel_x holds at 1023.
REQ-035 Locked stream -> frame_start pulses exactly once per 420000 clocks.
REQ-036 Reset pulsed at y=200 while locked -> all outputs zero the next cycle; lock is regained after 4 vsync edges with no sync_error.
